// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state,
// the zero-register index and the bundle of pipeline control strobes.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_e;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_RUN   = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                       idex_bubble: 1'b0, pipe_hold: 1'b0};
  localparam ctrl_out_t CTRL_HOLD  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b0, pipe_hold: 1'b1};
  localparam ctrl_out_t CTRL_FLUSH = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                       idex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam ctrl_out_t CTRL_STALL = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam ctrl_out_t CTRL_ERR   = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b1, pipe_hold: 1'b1};

  // A load in EX whose destination feeds a decode-stage source; XZR never conflicts.
  function automatic logic load_use_hazard(
    input logic [4:0] rd,
    input logic [4:0] rn,
    input logic [4:0] rmd,
    input logic       mem_read,
    input logic       reg_write,
    input logic       use_rn,
    input logic       use_rmd
  );
    return mem_read && reg_write && (rd != XZR) &&
           ((use_rn && (rn == rd)) || (use_rmd && (rmd == rd)));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Optional 32-bit event counters for load-use stalls, branch flushes and
// memory wait cycles; only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        lu_stall_i,
  input  logic        flush_i,
  input  logic        wait_i,
  input  logic        freeze_i,
  output logic [31:0] lu_stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] wait_cnt_o
);

  logic [31:0] luStallCnt_q;
  logic [31:0] flushCnt_q;
  logic [31:0] waitCnt_q;

  // Counters wrap naturally at 2^32 and stop moving once the controller has failed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      luStallCnt_q <= '0;
      flushCnt_q   <= '0;
      waitCnt_q    <= '0;
    end else if (!freeze_i) begin
      if (lu_stall_i) luStallCnt_q <= luStallCnt_q + 32'd1;
      if (flush_i)    flushCnt_q   <= flushCnt_q + 32'd1;
      if (wait_i)     waitCnt_q    <= waitCnt_q + 32'd1;
    end
  end

  assign lu_stall_cnt_o = luStallCnt_q;
  assign flush_cnt_o    = flushCnt_q;
  assign wait_cnt_o     = waitCnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-busy hold with timeout, branch flush and
// load-use stall. Define HAZARD_PERF_CNT_EN to add the event counter outputs.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rn_dec,
  input  logic [4:0] Rmd_dec,
  input  logic       useRn,
  input  logic       useRmd,
  input  logic [4:0] Rd_exe,
  input  logic       MemRead_exe,
  input  logic       RegWrite_exe,
  input  logic       BrTaken_exe,
  input  logic       mem_busy,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       pipe_hold,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] wait_cnt
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             memErr_q, memErr_d;
  logic             luHazard;
  ctrl_out_t        ctrl;

  assign luHazard = load_use_hazard(Rd_exe, Rn_dec, Rmd_dec, MemRead_exe,
                                    RegWrite_exe, useRn, useRmd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      waitCnt_q <= '0;
      memErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      memErr_q  <= memErr_d;
    end
  end

  // The counter holds the number of busy cycles seen so far in this wait.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    memErr_d  = memErr_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d   = MEM_WAIT;
          waitCnt_d = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d   = RUN;
          waitCnt_d = '0;
        end else if (waitCnt_q == CNT_LAST) begin
          state_d  = ERR;
          memErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + CNT_ONE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d   = RUN;
        waitCnt_d = '0;
      end
    endcase
  end

  // Mealy outputs; while reset is held the pipeline runs freely.
  always_comb begin
    ctrl = CTRL_RUN;
    if (reset) begin
      unique case (state_q)
        ERR: ctrl = CTRL_ERR;
        RUN, MEM_WAIT: begin
          if (mem_busy)         ctrl = CTRL_HOLD;
          else if (BrTaken_exe) ctrl = CTRL_FLUSH;
          else if (luHazard)    ctrl = CTRL_STALL;
        end
        default: ctrl = CTRL_RUN;
      endcase
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign pipe_hold   = ctrl.pipe_hold;
  assign mem_err     = memErr_q;

`ifdef HAZARD_PERF_CNT_EN
  logic luStallEv;
  logic flushEv;
  logic waitEv;

  assign luStallEv = ctrl.idex_bubble & ~ctrl.pc_we & ~ctrl.pipe_hold;
  assign flushEv   = ctrl.ifid_flush;
  assign waitEv    = ctrl.pipe_hold & ~ctrl.idex_bubble;

  hazard_perf_counters u_perf (
    .clk            (clk),
    .reset          (reset),
    .lu_stall_i     (luStallEv),
    .flush_i        (flushEv),
    .wait_i         (waitEv),
    .freeze_i       (state_q == ERR),
    .lu_stall_cnt_o (lu_stall_cnt),
    .flush_cnt_o    (flush_cnt),
    .wait_cnt_o     (wait_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push
// expected control bits; a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, mem_err}
  localparam logic [5:0] EXP_RUN   = 6'b110000;
  localparam logic [5:0] EXP_STALL = 6'b000100;
  localparam logic [5:0] EXP_FLUSH = 6'b111100;
  localparam logic [5:0] EXP_HOLD  = 6'b000010;
  localparam logic [5:0] EXP_ERR   = 6'b000111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] Rn_dec = '0, Rmd_dec = '0, Rd_exe = '0;
  logic       useRn = 1'b0, useRmd = 1'b0;
  logic       MemRead_exe = 1'b0, RegWrite_exe = 1'b0;
  logic       BrTaken_exe = 1'b0, mem_busy = 1'b0;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, flush_cnt, wait_cnt;
`endif

  logic [5:0] expQ[$];
  string      tagQ[$];
  logic       vecValid = 1'b0;
  int         vecCount = 0;
  int         missCount = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .Rn_dec       (Rn_dec),
    .Rmd_dec      (Rmd_dec),
    .useRn        (useRn),
    .useRmd       (useRmd),
    .Rd_exe       (Rd_exe),
    .MemRead_exe  (MemRead_exe),
    .RegWrite_exe (RegWrite_exe),
    .BrTaken_exe  (BrTaken_exe),
    .mem_busy     (mem_busy),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .pipe_hold    (pipe_hold),
    .mem_err      (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_stall_cnt (lu_stall_cnt),
    .flush_cnt    (flush_cnt),
    .wait_cnt     (wait_cnt)
`endif
  );

  // One vector occupies one clock cycle: inputs change just after the rising edge.
  task automatic applyStimulus(
    input logic rst, input logic mb, input logic br, input logic mr, input logic rw,
    input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rmd,
    input logic urn, input logic urmd, input logic [5:0] exp, input string tag
  );
    @(posedge clk);
    #1;
    reset        = rst;
    mem_busy     = mb;
    BrTaken_exe  = br;
    MemRead_exe  = mr;
    RegWrite_exe = rw;
    Rd_exe       = rd;
    Rn_dec       = rn;
    Rmd_dec      = rmd;
    useRn        = urn;
    useRmd       = urmd;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    vecValid     = 1'b1;
  endtask

  task automatic idle(input logic [5:0] exp, input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, exp, tag);
  endtask

  task automatic busy(input logic [5:0] exp, input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, exp, tag);
  endtask

  task automatic checkOutput(input logic [5:0] exp, input string tag);
    logic [5:0] act;
    act = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, mem_err};
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, expected %b (pc_we ifid_we flush bubble hold err)",
               tag, act, exp);
    end
  endtask

  // Monitor: consumes one expected entry per presented cycle.
  always @(negedge clk) begin
    if (vecValid) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        checkOutput(expQ.pop_front(), tagQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // reset behaviour, including forced outputs while reset is low
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_RUN, "reset_idle");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_RUN, "reset_forced");
    idle(EXP_RUN, "reset_release");

    // load-use detection
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, EXP_STALL, "lu_rn");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, EXP_RUN, "lu_no_repeat");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 5'd31, 5'd0, 1'b1, 1'b0, EXP_RUN, "lu_xzr");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b1, EXP_RUN, "lu_xzr_rmd");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, EXP_STALL, "lu_rmd");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, EXP_RUN, "lu_unused_src");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, EXP_RUN, "lu_no_regwrite");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, EXP_RUN, "alu_producer");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b1, EXP_RUN, "lu_no_match");

    // branch and priority
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, EXP_FLUSH, "br_over_lu");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_FLUSH, "br_only");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, EXP_HOLD, "busy_over_br");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_FLUSH, "wait_exit_br");

    // short memory waits
    for (int i = 0; i < 3; i++) busy(EXP_HOLD, "busy3");
    idle(EXP_RUN, "busy3_release");
    busy(EXP_HOLD, "busy2");
    busy(EXP_HOLD, "busy2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 5'd12, 5'd0, 1'b1, 1'b0, EXP_STALL, "wait_exit_lu");

    // asynchronous reset in the middle of a wait
    busy(EXP_HOLD, "busy_pre_reset");
    busy(EXP_HOLD, "busy_pre_reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_RUN, "reset_mid_wait");
    idle(EXP_RUN, "reset_mid_release");

    // timeout: 16 busy cycles reach ERR, then ERR ignores everything
    for (int i = 0; i < 20; i++) busy((i < MEM_TIMEOUT) ? EXP_HOLD : EXP_ERR, "timeout");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_ERR, "err_ignores_br");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, EXP_ERR, "err_ignores_lu");
    idle(EXP_ERR, "err_sticky");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_RUN, "reset_from_err");
    idle(EXP_RUN, "after_err_reset");
    busy(EXP_HOLD, "after_err_busy");
    idle(EXP_RUN, "after_err_release");

    // clean counters, then two load-use stalls and one flush
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_RUN, "reset_perf");
    idle(EXP_RUN, "perf_idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, EXP_STALL, "perf_lu1");
    idle(EXP_RUN, "perf_idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b1, EXP_STALL, "perf_lu2");
    idle(EXP_RUN, "perf_idle");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_FLUSH, "perf_br");
    idle(EXP_RUN, "perf_idle");

    @(negedge clk);
    #1;
    vecValid = 1'b0;
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
    end

`ifdef HAZARD_PERF_CNT_EN
    vecCount++;
    if (lu_stall_cnt !== 32'd2) begin
      missCount++;
      $display("[TB] FAIL lu_stall_cnt: got %0d, expected 2", lu_stall_cnt);
    end
    vecCount++;
    if (flush_cnt !== 32'd1) begin
      missCount++;
      $display("[TB] FAIL flush_cnt: got %0d, expected 1", flush_cnt);
    end
    vecCount++;
    if (wait_cnt !== 32'd0) begin
      missCount++;
      $display("[TB] FAIL wait_cnt: got %0d, expected 0", wait_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
